// File: rtl/alarm_ring_controller_pkg.sv
// Shared encodings and constants for the alarm ring controller.
// Also used by the minute-of-day adder and the time counters.
package alarm_ring_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  localparam logic [10:0] MIN_PER_DAY = 11'd1440;

endpackage

// File: rtl/alarm_ring_controller_mod_day_add.sv
// mod_day_add: combinational (a + b) mod 1440 on minute-of-day values.
// Both operands must already be in 0..1439.
module mod_day_add
  import alarm_ring_controller_pkg::*;
(
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic [10:0] sum
);

  logic [11:0] raw;
  logic [10:0] wrap;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b};
    // 11-bit modular subtract is exact: true result is < 1440
    wrap = raw[10:0] - MIN_PER_DAY;
    sum  = (raw >= {1'b0, MIN_PER_DAY}) ? wrap : raw[10:0];
  end

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer: minute match, 1 Hz beep, dismiss, timeout.
// Optional snooze path enabled by defining ALARM_SNOOZE_EN.
module alarm_ring_controller
  import alarm_ring_controller_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [10:0] cur_mod,
  input  logic [10:0] alarm_mod,
  input  logic        alarm_en,
  input  logic        editing,
  input  logic        btn_dismiss,
  input  logic        btn_snooze,
  output logic        buzzer,
  output logic        ringing,
  output logic        snoozed,
  output logic [1:0]  snooze_cnt
);

  localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

  state_e     state_q, state_d;
  logic       beep_q, beep_d;
  logic [7:0] sec_q, sec_d;
  logic       match_q;
  logic       gate, match, fire, stop, go_idle;

`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0]  SNZ_MAX = 2'(MAX_SNOOZE);
  localparam logic [10:0] SNZ_ADD = 11'(SNOOZE_MIN);

  logic [1:0]  cnt_q, cnt_d;
  logic [10:0] start_q, start_d;
  logic [10:0] tgt_q, tgt_d;
  logic [10:0] tgt_sum;
  logic        smatch, smatch_q, sfire;

  mod_day_add u_snz_add (
    .a   (start_q),
    .b   (SNZ_ADD),
    .sum (tgt_sum)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{8'(SNOOZE_MIN), 2'(MAX_SNOOZE)};
`endif

  always_comb begin
    gate    = alarm_en & ~editing;
    match   = gate & (cur_mod == alarm_mod);
    fire    = match & ~match_q;
    state_d = state_q;
    beep_d  = beep_q;
    sec_d   = sec_q;
    go_idle = 1'b0;
`ifdef ALARM_SNOOZE_EN
    stop    = btn_dismiss;
    smatch  = gate & (cur_mod == tgt_q);
    sfire   = smatch & ~smatch_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    tgt_d   = tgt_q;
`else
    stop    = btn_dismiss | btn_snooze;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d = ST_RING;
          sec_d   = 8'd0;
          beep_d  = 1'b1;
`ifdef ALARM_SNOOZE_EN
          cnt_d   = 2'd0;
          start_d = cur_mod;
`endif
        end
      end
      ST_RING: begin
        if (stop) begin
          go_idle = 1'b1;
`ifdef ALARM_SNOOZE_EN
        end else if (btn_snooze) begin
          if (cnt_q < SNZ_MAX) begin
            state_d = ST_SNOOZE;
            cnt_d   = cnt_q + 2'd1;
            tgt_d   = tgt_sum;
            beep_d  = 1'b0;
          end else begin
            go_idle = 1'b1;
          end
`endif
        end else if (tick_1hz) begin
          if (sec_q == RING_LAST) begin
            go_idle = 1'b1;
          end else begin
            sec_d  = sec_q + 8'd1;
            beep_d = ~beep_q;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (sfire) begin
          state_d = ST_RING;
          sec_d   = 8'd0;
          beep_d  = 1'b1;
          start_d = tgt_q;
        end
      end
`endif
      default: go_idle = 1'b1;
    endcase

    if (!gate) go_idle = 1'b1;

    if (go_idle) begin
      state_d = ST_IDLE;
      beep_d  = 1'b0;
      sec_d   = 8'd0;
`ifdef ALARM_SNOOZE_EN
      cnt_d   = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beep_q   <= 1'b0;
      sec_q    <= 8'd0;
      match_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      cnt_q    <= 2'd0;
      start_q  <= 11'd0;
      tgt_q    <= 11'd0;
      smatch_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beep_q   <= beep_d;
      sec_q    <= sec_d;
      match_q  <= match;
`ifdef ALARM_SNOOZE_EN
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      tgt_q    <= tgt_d;
      smatch_q <= smatch;
`endif
    end
  end

  // Output gate drops the beep in the same clk as disarm/edit
  assign buzzer  = beep_q & gate;
  assign ringing = (state_q == ST_RING);

`ifdef ALARM_SNOOZE_EN
  assign snoozed    = (state_q == ST_SNOOZE);
  assign snooze_cnt = cnt_q;
`else
  assign snoozed    = 1'b0;
  assign snooze_cnt = 2'd0;
`endif

endmodule
